fetch_unit: RTL and testbench

//  Instruction-fetch and program-counter stage of the 4-phase CPU.
//  - Consumes the phase levels from the clock generator (PHASE_FT, PHASE_WB) as synchronous data.
//  - Detects their rising edges.
//  - Fetches one instruction per fetch phase from synchronous ROM into IR.
//  - Advances or redirects PC on each writeback phase.
//  - Feeds decode with IR/IR_VALID.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_unit_phase_edge_det.sv | 17 +
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;
  localparam int ADDR_W_DEF   = 8;
  localparam int INSN_W_DEF   = 15;
  localparam int RETIRE_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: phase levels, ROM port, branch/halt controls and fetch outputs.
// Optional macro FETCH_RETIRE_CNT_EN adds RETIRE_CNT.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF
);
  logic              PHASE_FT;
  logic              PHASE_WB;
  logic [INSN_W-1:0] ROM_DATA;
  logic              JUMP;
  logic [ADDR_W-1:0] JUMP_ADDR;
  logic              HALT;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [ADDR_W-1:0] PC;
  logic [INSN_W-1:0] IR;
  logic              IR_VALID;
  logic              HALTED;
`ifdef FETCH_RETIRE_CNT_EN
  logic [RETIRE_CNT_W-1:0] RETIRE_CNT;
`endif

  // fetch unit side
  modport master (
    input  PHASE_FT, PHASE_WB, ROM_DATA, JUMP, JUMP_ADDR, HALT,
`ifdef FETCH_RETIRE_CNT_EN
    output RETIRE_CNT,
`endif
    output ROM_ADDR, PC, IR, IR_VALID, HALTED
  );

  // clock generator / ROM / decode side
  modport slave (
    output PHASE_FT, PHASE_WB, ROM_DATA, JUMP, JUMP_ADDR, HALT,
`ifdef FETCH_RETIRE_CNT_EN
    input  RETIRE_CNT,
`endif
    input  ROM_ADDR, PC, IR, IR_VALID, HALTED
  );
endinterface

// File: rtl/fetch_unit_phase_edge_det.sv
// Rising-edge detector for a phase level that is synchronous to CLK.
module phase_edge_det (
  input  logic CLK,
  input  logic RESET,
  input  logic level,
  output logic rise
);
  logic level_q;

  // remember last cycle's level
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / program-counter stage of the 4-phase CPU.
// Optional macro FETCH_RETIRE_CNT_EN enables a saturating retire counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSN_W   = INSN_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         CLK,
  input logic         RESET,
  fetch_unit_if.master bus
);
  fetch_state_t      state, state_nxt;
  logic              ft_rise, wb_rise;
  logic              halted, capture, wb_take;
  logic [ADDR_W-1:0] pc;
  logic [INSN_W-1:0] ir;
  logic              ir_valid;

  phase_edge_det u_ft_edge (.CLK(CLK), .RESET(RESET), .level(bus.PHASE_FT), .rise(ft_rise));
  phase_edge_det u_wb_edge (.CLK(CLK), .RESET(RESET), .level(bus.PHASE_WB), .rise(wb_rise));

  assign halted  = (state == S_HALT);
  assign capture = (state == S_READ);
  // once halted, the whole stage is frozen until reset
  assign wb_take = wb_rise & ~halted;

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state; a halting writeback overrides fetch start but a capture in S_READ still lands
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (ft_rise) state_nxt = S_READ;
      S_READ:  state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
    if (wb_rise && bus.HALT) state_nxt = S_HALT;
  end

  // program counter: advance or redirect on writeback
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        pc <= RESET_PC;
    else if (wb_take) pc <= bus.JUMP ? bus.JUMP_ADDR : pc + ADDR_W'(1);
  end

  // instruction register; capture has priority over the writeback clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (capture) begin
      ir       <= bus.ROM_DATA;
      ir_valid <= 1'b1;
    end else if (wb_take) begin
      ir_valid <= 1'b0;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [RETIRE_CNT_W-1:0] retire_cnt;

  // count retired instructions, saturating
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                        retire_cnt <= '0;
    else if (wb_take && ir_valid && retire_cnt != '1) retire_cnt <= retire_cnt + RETIRE_CNT_W'(1);
  end

  assign bus.RETIRE_CNT = retire_cnt;
`endif

  assign bus.ROM_ADDR = pc;
  assign bus.PC       = pc;
  assign bus.IR       = ir;
  assign bus.IR_VALID = ir_valid;
  assign bus.HALTED   = halted;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized phase traffic
// checked every cycle against a transaction-level reference model.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 15;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  fetch_unit_if #(.ADDR_W(AW), .INSN_W(IW)) bus ();

  fetch_unit #(.ADDR_W(AW), .INSN_W(IW), .RESET_PC(8'h00)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  // synchronous ROM: data for an address appears one cycle later
  logic [IW-1:0] rom [256];
  logic [IW-1:0] rom_q;
  always @(posedge CLK) rom_q <= rom[bus.ROM_ADDR];
  assign bus.ROM_DATA = rom_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: phase events as transactions
  logic [AW-1:0] m_pc    = '0;
  logic [IW-1:0] m_ir    = '0;
  logic          m_valid = 1'b0;
  logic          m_halt  = 1'b0;
  logic          m_pft   = 1'b0;
  logic          m_pwb   = 1'b0;
  logic          m_pend  = 1'b0;
  logic [IW-1:0] m_pdata = '0;
  int            m_cnt   = 0;

  always @(posedge CLK or posedge RESET) begin
    logic ftr, wbr, v_old;
    if (RESET) begin
      m_pc = '0; m_ir = '0; m_valid = 1'b0; m_halt = 1'b0;
      m_pft = 1'b0; m_pwb = 1'b0; m_pend = 1'b0; m_cnt = 0;
    end else begin
      ftr = bus.PHASE_FT && !m_pft;
      wbr = bus.PHASE_WB && !m_pwb;
      m_pft = bus.PHASE_FT;
      m_pwb = bus.PHASE_WB;
      if (!m_halt) begin
        v_old = m_valid;
        if (m_pend) begin
          m_ir    = m_pdata;
          m_valid = 1'b1;
        end else if (wbr) begin
          m_valid = 1'b0;
        end
        m_pend  = ftr && !(wbr && bus.HALT);
        m_pdata = rom[m_pc];
        if (wbr) begin
          if (v_old && m_cnt < 65535) m_cnt++;
          m_pc = bus.JUMP ? bus.JUMP_ADDR : 8'(m_pc + 8'd1);
          if (bus.HALT) m_halt = 1'b1;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge CLK) begin
    chk("pc",       32'(bus.PC),       32'(m_pc));
    chk("rom_addr", 32'(bus.ROM_ADDR), 32'(m_pc));
    chk("ir",       32'(bus.IR),       32'(m_ir));
    chk("ir_valid", 32'(bus.IR_VALID), 32'(m_valid));
    chk("halted",   32'(bus.HALTED),   32'(m_halt));
`ifdef FETCH_RETIRE_CNT_EN
    chk("retire_cnt", 32'(bus.RETIRE_CNT), 32'(m_cnt));
`endif
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},     32'(bus.PC),       32'h0);
    chk({tag, "_ir"},     32'(bus.IR),       32'h0);
    chk({tag, "_valid"},  32'(bus.IR_VALID), 32'h0);
    chk({tag, "_halted"}, 32'(bus.HALTED),   32'h0);
  endtask

  initial begin
    int hcnt;
    logic [IW-1:0] ir_ff;
    bus.PHASE_FT  = 1'b0;
    bus.PHASE_WB  = 1'b0;
    bus.JUMP      = 1'b0;
    bus.JUMP_ADDR = '0;
    bus.HALT      = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom);
    rom[0]     = 15'h1234;
    rom[8'h40] = 15'h2A5A;
    ir_ff      = rom[8'hFF];

    #1;
    chk_reset_vals("por");
    tick(2);
    RESET = 1'b0;
    tick(2);

    // basic fetch, then phase held high: one fetch only
    bus.PHASE_FT = 1'b1;
    tick(1);
    chk("fetch_lat_valid", 32'(bus.IR_VALID), 32'h0);
    tick(1);
    chk("fetch_ir",    32'(bus.IR),       32'h1234);
    chk("fetch_valid", 32'(bus.IR_VALID), 32'h1);
    chk("fetch_pc",    32'(bus.PC),       32'h0);
    rom[0] = 15'h0555;
    tick(4);
    chk("held_ir", 32'(bus.IR), 32'h1234);
    bus.PHASE_FT = 1'b0;
    tick(1);

    // jump, and no retrigger / off-edge jump ignored
    bus.JUMP = 1'b1; bus.JUMP_ADDR = 8'h40; bus.PHASE_WB = 1'b1;
    tick(1);
    chk("jump_pc",    32'(bus.PC),       32'h40);
    chk("jump_valid", 32'(bus.IR_VALID), 32'h0);
    bus.JUMP_ADDR = 8'h77;
    tick(2);
    chk("jump_offedge_pc", 32'(bus.PC), 32'h40);
    bus.PHASE_WB = 1'b0; bus.JUMP = 1'b0;
    tick(1);
    bus.PHASE_FT = 1'b1;
    tick(1);
    chk("jump_rom_addr", 32'(bus.ROM_ADDR), 32'h40);
    tick(1);
    chk("jump_fetch_ir", 32'(bus.IR), 32'h2A5A);
    bus.PHASE_FT = 1'b0;
    tick(1);

    // PC wrap from FF
    bus.JUMP = 1'b1; bus.JUMP_ADDR = 8'hFF; bus.PHASE_WB = 1'b1;
    tick(1);
    bus.PHASE_WB = 1'b0; bus.JUMP = 1'b0;
    tick(1);
    bus.PHASE_FT = 1'b1;
    tick(2);
    bus.PHASE_FT = 1'b0;
    tick(1);
    bus.PHASE_WB = 1'b1;
    tick(1);
    chk("wrap_pc",    32'(bus.PC),       32'h00);
    chk("wrap_valid", 32'(bus.IR_VALID), 32'h0);
    bus.PHASE_WB = 1'b0;
    tick(1);

    // halt at PC=3
    bus.JUMP = 1'b1; bus.JUMP_ADDR = 8'h03; bus.PHASE_WB = 1'b1;
    tick(1);
    bus.PHASE_WB = 1'b0; bus.JUMP = 1'b0;
    tick(1);
    bus.HALT = 1'b1; bus.PHASE_WB = 1'b1;
    tick(1);
    chk("halt_pc",     32'(bus.PC),     32'h4);
    chk("halt_halted", 32'(bus.HALTED), 32'h1);
    bus.HALT = 1'b0; bus.PHASE_WB = 1'b0;
    bus.PHASE_FT = 1'b1;
    tick(3);
    bus.PHASE_FT = 1'b0;
    tick(1);
    chk("halt_ir",    32'(bus.IR),       32'(ir_ff));
    chk("halt_valid", 32'(bus.IR_VALID), 32'h0);
    bus.PHASE_WB = 1'b1;
    tick(1);
    chk("halt_frozen_pc", 32'(bus.PC), 32'h4);

    // asynchronous reset mid-cycle, phase level active
    #2 RESET = 1'b1;
    #1 chk_reset_vals("async");
    tick(1);
    bus.PHASE_WB = 1'b0;
    RESET = 1'b0;
    tick(1);

    // three full fetch/writeback rounds
    for (int r = 0; r < 3; r++) begin
      bus.PHASE_FT = 1'b1;
      tick(2);
      bus.PHASE_FT = 1'b0;
      tick(1);
      bus.PHASE_WB = 1'b1;
      tick(1);
      bus.PHASE_WB = 1'b0;
      tick(1);
    end
    chk("rounds_pc", 32'(bus.PC), 32'h3);
`ifdef FETCH_RETIRE_CNT_EN
    chk("rounds_retire", 32'(bus.RETIRE_CNT), 32'h3);
`endif

    // randomized phase traffic
    hcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.PHASE_FT  = 1'($urandom_range(0, 1));
      bus.PHASE_WB  = 1'($urandom_range(0, 1));
      bus.JUMP      = ($urandom_range(0, 3) == 0);
      bus.JUMP_ADDR = 8'($urandom);
      bus.HALT      = ($urandom_range(0, 40) == 0);
      if (m_halt) hcnt++;
      if (hcnt > 10 || $urandom_range(0, 250) == 0) begin
        hcnt = 0;
        #2 RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
      end else begin
        tick(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
